// File: rtl/cmd_sequencer.sv
// Command sequencer: frames a 48-bit command with a serial CRC7, hands it to the
// physical layer, collects the response with timeout/retry and reports completion.
module cmd_sequencer #(
    parameter int RESP_W    = 136,
    parameter int TO_W      = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              new_command,
    input  logic [5:0]        cmd_index,
    input  logic [31:0]       cmd_argument,
    input  logic [1:0]        resp_type,
    input  logic              timeout_enable,
    input  logic [TO_W-1:0]   timeout_value,
    input  logic              ack_in,
    input  logic              strobe_in,
    input  logic [RESP_W-1:0] cmd_in,
    input  logic              ack_command_complete,
    output logic [47:0]       cmd_out,
    output logic              strobe_out,
    output logic              ack_out,
    output logic              idle_out,
    output logic [RESP_W-1:0] response,
    output logic              command_complete,
    output logic              cmd_error,
    output logic [1:0]        error_code
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_SEND,
        ST_WAIT_RESP,
        ST_COMPLETE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [5:0]          r_index;
    logic [31:0]         r_argument;
    logic [1:0]          r_resp_type;
    logic [39:0]         r_shift;
    logic [6:0]          r_crc;
    logic [5:0]          r_bit_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [RETRY_W-1:0]  r_retry;
    logic [47:0]         r_cmd_out;
    logic [RESP_W-1:0]   r_response;
    logic [1:0]          r_error_code;
    logic                r_ack_out;

    logic                w_fb;
    logic [6:0]          w_crc_next;
    logic                w_timeout;
    logic                w_index_mismatch;
    logic                w_start;
    logic                w_crc_last;
    logic                w_enter_wait;
    logic                w_accept;
    logic                w_retry;
    logic                w_done_none;
    logic                w_timeout_fail;

    // Serial CRC7 (x^7 + x^3 + 1), message bits enter MSB first from the shifter.
    assign w_fb       = r_shift[39] ^ r_crc[6];
    assign w_crc_next = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};

    assign w_timeout        = timeout_enable && (r_to_cnt == timeout_value);
    assign w_index_mismatch = (r_resp_type == 2'b01) && (cmd_in[45:40] != r_index);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_start          = 1'b0;
        w_crc_last       = 1'b0;
        w_enter_wait     = 1'b0;
        w_accept         = 1'b0;
        w_retry          = 1'b0;
        w_done_none      = 1'b0;
        w_timeout_fail   = 1'b0;
        idle_out         = 1'b0;
        strobe_out       = 1'b0;
        command_complete = 1'b0;
        cmd_error        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                idle_out = 1'b1;
                if (new_command) begin
                    w_start      = 1'b1;
                    w_state_next = ST_CRC;
                end
            end
            ST_CRC: begin
                if (r_bit_cnt == 6'd39) begin
                    w_crc_last   = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                strobe_out = 1'b1;
                if (ack_in) begin
                    if (r_resp_type == 2'b00) begin
                        w_done_none  = 1'b1;
                        w_state_next = ST_COMPLETE;
                    end else begin
                        w_enter_wait = 1'b1;
                        w_state_next = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                // A response arriving in the timeout cycle wins over the timeout.
                if (strobe_in) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_COMPLETE;
                end else if (w_timeout) begin
                    if (r_retry < RETRY_W'(MAX_RETRY)) begin
                        w_retry      = 1'b1;
                        w_state_next = ST_SEND;
                    end else begin
                        w_timeout_fail = 1'b1;
                        w_state_next   = ST_COMPLETE;
                    end
                end
            end
            ST_COMPLETE: begin
                command_complete = 1'b1;
                cmd_error        = (r_error_code != 2'b00);
                if (ack_command_complete) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_index     <= '0;
            r_argument  <= '0;
            r_resp_type <= '0;
            r_shift     <= '0;
            r_crc       <= '0;
            r_bit_cnt   <= '0;
        end else if (w_start) begin
            r_index     <= cmd_index;
            r_argument  <= cmd_argument;
            r_resp_type <= resp_type;
            r_shift     <= {2'b01, cmd_index, cmd_argument};
            r_crc       <= '0;
            r_bit_cnt   <= '0;
        end else if (r_state == ST_CRC) begin
            r_shift     <= {r_shift[38:0], 1'b0};
            r_crc       <= w_crc_next;
            r_bit_cnt   <= r_bit_cnt + 6'd1;
        end
    end

    // The frame register is only written once the final CRC bit is known.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmd_out <= '0;
        end else if (w_crc_last) begin
            r_cmd_out <= {2'b01, r_index, r_argument, w_crc_next, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retry  <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_start) begin
                r_retry <= '0;
            end else if (w_retry) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
            if (w_enter_wait) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_WAIT_RESP) && !strobe_in) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_response   <= '0;
            r_error_code <= 2'b00;
            r_ack_out    <= 1'b0;
        end else begin
            r_ack_out <= w_accept;
            if (w_accept) begin
                r_response   <= cmd_in;
                r_error_code <= w_index_mismatch ? 2'b10 : 2'b00;
            end else if (w_timeout_fail) begin
                r_error_code <= 2'b01;
            end else if (w_done_none) begin
                r_error_code <= 2'b00;
            end
        end
    end

    assign cmd_out    = r_cmd_out;
    assign response   = r_response;
    assign error_code = r_error_code;
    assign ack_out    = r_ack_out;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: directed commands checked every cycle against a
// behavioural model, plus literal frame/status expectations per command.
module tb_cmd_sequencer;

    localparam int RESP_W    = 136;
    localparam int TO_W      = 16;
    localparam int MAX_RETRY = 2;

    localparam int P_IDLE = 0, P_CRC = 1, P_SEND = 2, P_WAIT = 3, P_DONE = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              new_command;
    logic [5:0]        cmd_index;
    logic [31:0]       cmd_argument;
    logic [1:0]        resp_type;
    logic              timeout_enable;
    logic [TO_W-1:0]   timeout_value;
    logic              ack_in;
    logic              strobe_in;
    logic [RESP_W-1:0] cmd_in;
    logic              ack_command_complete;
    logic [47:0]       cmd_out;
    logic              strobe_out;
    logic              ack_out;
    logic              idle_out;
    logic [RESP_W-1:0] response;
    logic              command_complete;
    logic              cmd_error;
    logic [1:0]        error_code;

    always #5 clock = ~clock;

    cmd_sequencer #(.RESP_W(RESP_W), .TO_W(TO_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clock(clock), .reset(reset), .new_command(new_command),
        .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_type(resp_type),
        .timeout_enable(timeout_enable), .timeout_value(timeout_value),
        .ack_in(ack_in), .strobe_in(strobe_in), .cmd_in(cmd_in),
        .ack_command_complete(ack_command_complete), .cmd_out(cmd_out),
        .strobe_out(strobe_out), .ack_out(ack_out), .idle_out(idle_out),
        .response(response), .command_complete(command_complete),
        .cmd_error(cmd_error), .error_code(error_code)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_complete = 0;
    bit chk_en = 1'b0;
    logic prev_cc = 1'b0;

    task automatic chk(input string name, input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame = 40-bit message followed by its CRC7 (remainder of msg*x^7 mod 0x89) and a stop bit.
    function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, arg};
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return {m, r[6:0], 1'b1};
    endfunction

    int                m_phase, m_crc_cnt, m_wait_cnt, m_retries;
    logic [5:0]        m_idx;
    logic [31:0]       m_arg;
    logic [1:0]        m_rt;
    logic [47:0]       e_cmd_out;
    logic [RESP_W-1:0] e_resp;
    logic [1:0]        e_err;
    logic              e_ack;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = P_IDLE; m_crc_cnt = 0; m_wait_cnt = 0; m_retries = 0;
            e_cmd_out = '0; e_resp = '0; e_err = 2'b00; e_ack = 1'b0;
        end else begin
            e_ack = 1'b0;
            case (m_phase)
                P_IDLE: if (new_command) begin
                    m_idx = cmd_index; m_arg = cmd_argument; m_rt = resp_type;
                    m_retries = 0; m_crc_cnt = 0; m_phase = P_CRC;
                end
                P_CRC: begin
                    m_crc_cnt++;
                    if (m_crc_cnt == 40) begin
                        e_cmd_out = frame_of(m_idx, m_arg);
                        m_phase = P_SEND;
                    end
                end
                P_SEND: if (ack_in) begin
                    if (m_rt == 2'b00) begin e_err = 2'b00; m_phase = P_DONE; end
                    else begin m_wait_cnt = 0; m_phase = P_WAIT; end
                end
                P_WAIT: begin
                    if (strobe_in) begin
                        e_resp = cmd_in; e_ack = 1'b1;
                        e_err = (m_rt == 2'b01 && cmd_in[45:40] != m_idx) ? 2'b10 : 2'b00;
                        m_phase = P_DONE;
                    end else if (timeout_enable && m_wait_cnt == int'(timeout_value)) begin
                        if (m_retries < MAX_RETRY) begin m_retries++; m_phase = P_SEND; end
                        else begin e_err = 2'b01; m_phase = P_DONE; end
                    end else begin
                        m_wait_cnt++;
                    end
                end
                default: if (ack_command_complete) m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("idle_out", idle_out, m_phase == P_IDLE);
            chk("strobe_out", strobe_out, m_phase == P_SEND);
            chk("command_complete", command_complete, m_phase == P_DONE);
            chk("cmd_error", cmd_error, (m_phase == P_DONE) && (e_err != 2'b00));
            chk("ack_out", ack_out, e_ack);
            chk("cmd_out", cmd_out, e_cmd_out);
            chk("response", response, e_resp);
            chk("error_code", error_code, e_err);
            if (command_complete && !prev_cc) n_complete++;
            prev_cc = command_complete;
        end
    end

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input int resp_after, input logic [RESP_W-1:0] resp, input bit spur,
                          output int sends, output int lat, output int acks,
                          output logic [1:0] err, output logic cerr);
        int cyc, wcnt;
        bit done, prev;
        sends = 0; lat = -1; acks = 0; err = 2'b00; cerr = 1'b0;
        wcnt = -1; done = 1'b0; prev = 1'b0;
        new_command = 1'b1; cmd_index = idx; cmd_argument = arg; resp_type = rt;
        @(negedge clock);
        new_command = 1'b0;
        cyc = 1;
        while (!done) begin
            if (strobe_out && !prev) begin
                sends++;
                if (lat < 0) lat = cyc;
            end
            prev = strobe_out;
            if (ack_out) acks++;
            strobe_in = 1'b0;
            new_command = 1'b0;
            if (wcnt >= 0) begin
                wcnt++;
                if (resp_after >= 0 && wcnt - 1 == resp_after) begin
                    strobe_in = 1'b1;
                    cmd_in = resp;
                end
                if (spur && wcnt == 2) new_command = 1'b1;
            end
            ack_in = strobe_out;
            if (strobe_out && wcnt < 0) wcnt = 0;
            if (command_complete) begin
                done = 1'b1; err = error_code; cerr = cmd_error;
            end else if (cyc >= 3000) begin
                n_checks++; n_fail++;
                $display("FAIL cmd_wait: no completion after %0d cycles", cyc);
                done = 1'b1;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        strobe_in = 1'b0; ack_in = 1'b0; new_command = 1'b0;
        ack_command_complete = 1'b1;
        @(negedge clock);
        ack_command_complete = 1'b0;
    endtask

    int sends, lat, acks, c0;
    logic [1:0] err;
    logic cerr;
    logic [RESP_W-1:0] rsp;

    initial begin
        reset = 1'b0; new_command = 1'b0; cmd_index = '0; cmd_argument = '0; resp_type = '0;
        timeout_enable = 1'b0; timeout_value = '0; ack_in = 1'b0; strobe_in = 1'b0;
        cmd_in = '0; ack_command_complete = 1'b0;
        repeat (2) @(posedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_idle_out", idle_out, 1'b1);
        chk("rst_cmd_out", cmd_out, '0);
        chk("rst_complete", command_complete, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // CMD0, no response
        do_cmd(6'd0, 32'h0, 2'b00, -1, '0, 1'b0, sends, lat, acks, err, cerr);
        chk("cmd0_latency", lat, 41);
        chk("cmd0_frame", cmd_out, 48'h400000000095);
        chk("cmd0_sends", sends, 1);
        chk("cmd0_err", err, 2'b00);

        // CMD17, short response
        rsp = {88'h0, 48'h110000000901};
        do_cmd(6'd17, 32'h0, 2'b01, 2, rsp, 1'b0, sends, lat, acks, err, cerr);
        chk("cmd17_frame", cmd_out, 48'h510000000055);
        chk("cmd17_ack_pulses", acks, 1);
        chk("cmd17_response", response, rsp);
        chk("cmd17_err", err, 2'b00);

        // CMD8, timeout with retries
        timeout_enable = 1'b1; timeout_value = 16'd5;
        do_cmd(6'd8, 32'h000001AA, 2'b01, -1, '0, 1'b0, sends, lat, acks, err, cerr);
        chk("cmd8_frame", cmd_out, 48'h48000001AA87);
        chk("cmd8_sends", sends, 3);
        chk("cmd8_err", err, 2'b01);
        chk("cmd8_cmd_error", cerr, 1'b1);
        chk("cmd8_response_held", response, rsp);

        // CMD8, index mismatch in short response
        timeout_value = 16'd20;
        do_cmd(6'd8, 32'h000001AA, 2'b01, 1, {88'h0, 48'h090000000001}, 1'b0, sends, lat, acks, err, cerr);
        chk("mismatch_err", err, 2'b10);
        chk("mismatch_sends", sends, 1);
        chk("mismatch_cmd_error", cerr, 1'b1);

        // Response in the same cycle as the timeout
        timeout_value = 16'd3;
        rsp = {88'h0, 48'h110000000900};
        do_cmd(6'd17, 32'h00001234, 2'b01, 3, rsp, 1'b0, sends, lat, acks, err, cerr);
        chk("collide_err", err, 2'b00);
        chk("collide_sends", sends, 1);
        chk("collide_response", response, rsp);

        // Long response, index field not checked; no timeout for a long wait
        timeout_enable = 1'b0; timeout_value = 16'd0;
        rsp = {8'h3F, 128'hDEADBEEF_01234567_89ABCDEF_55AA33CC};
        do_cmd(6'd2, 32'h0, 2'b10, 100, rsp, 1'b0, sends, lat, acks, err, cerr);
        chk("long_err", err, 2'b00);
        chk("long_response", response, rsp);

        // timeout_value = 0 fires in the first wait cycle
        timeout_enable = 1'b1; timeout_value = 16'd0;
        do_cmd(6'd55, 32'hCAFEF00D, 2'b01, -1, '0, 1'b0, sends, lat, acks, err, cerr);
        chk("tov0_sends", sends, 3);
        chk("tov0_err", err, 2'b01);

        // Reset in the middle of CRC, then a command that ignores a spurious start
        timeout_enable = 1'b0;
        new_command = 1'b1; cmd_index = 6'd17; cmd_argument = 32'h0; resp_type = 2'b01;
        @(negedge clock);
        new_command = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        chk("rst2_cmd_out", cmd_out, '0);
        chk("rst2_response", response, '0);
        chk("rst2_err", error_code, 2'b00);
        chk("rst2_idle", idle_out, 1'b1);
        repeat (20) @(negedge clock);
        c0 = n_complete;
        rsp = {88'h0, 48'h110000000900};
        do_cmd(6'd17, 32'h0, 2'b01, 8, rsp, 1'b1, sends, lat, acks, err, cerr);
        repeat (50) @(negedge clock);
        chk("rst2_completions", n_complete - c0, 1);
        chk("rst2_final_idle", idle_out, 1'b1);
        chk("rst2_err", err, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
